// File: rtl/pc_unit_pkg.sv
// Shared opcode and control-state encodings for the program counter unit.
// Imported by the RTL and by the bench so both use one source of truth.
package pc_unit_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_INC  = 3'b001,
        OP_JUMP = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100
    } op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/pc_unit_return_stack.sv
// LIFO of return addresses; the caller guarantees push only when not full
// and pop only when not empty.
module return_stack #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int AW   = $clog2(STACK_DEPTH);
    localparam int SP_W = AW + 1;
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [AW-1:0]   IDX_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_d;
    logic [AW-1:0]    top_idx_s;

    assign empty     = (sp_q == {SP_W{1'b0}});
    assign full      = (sp_q == SP_FULL);
    assign top_idx_s = sp_q[AW-1:0] - IDX_ONE;
    assign top       = empty ? {WIDTH{1'b0}} : mem_q[top_idx_s];

    // Stack pointer next value.
    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SP_ONE;
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_ONE;
        end else begin
            sp_d = sp_q;
        end
    end

    // Stack pointer register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sp_q <= {SP_W{1'b0}};
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage; the slot at sp is written on push.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push && !full) begin
            mem_q[sp_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with return stack and a RUN/HALT control FSM; any stack
// misuse halts the PC until the next reset.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               STACK_DEPTH  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 8'h00
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             enable,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             fault
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_inc_s;
    logic [WIDTH-1:0] stack_top_s;
    logic             push_s;
    logic             pop_s;

    assign pc_inc_s = pc_q + WIDTH'(1);

    return_stack #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock     (clock),
        .clear_n   (clear_n),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top       (stack_top_s),
        .empty     (stack_empty),
        .full      (stack_full)
    );

    // Next-PC mux, stack control and RUN/HALT transitions.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        if (enable && (state_q == ST_RUN)) begin
            case (op)
                OP_INC:  pc_d = pc_inc_s;
                OP_JUMP: pc_d = target;
                OP_CALL: begin
                    if (stack_full) begin
                        state_d = ST_HALT;
                    end else begin
                        push_s = 1'b1;
                        pc_d   = target;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        state_d = ST_HALT;
                    end else begin
                        pop_s = 1'b1;
                        pc_d  = stack_top_s;
                    end
                end
                default: pc_d = pc_q;
            endcase
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and control-state registers.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            pc_q    <= RESET_VECTOR;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign pc    = pc_q;
    assign fault = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a queue-based reference model predicts each
// edge's outputs, and an independent monitor compares them on the falling edge.
module tb_pc_unit;
    import pc_unit_pkg::*;

    typedef struct packed {
        logic [7:0] pc;
        logic       empty;
        logic       full;
        logic       fault;
    } exp_t;

    logic       clock = 1'b0;
    logic       clear_n = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] op = 3'b000;
    logic [7:0] target = 8'h00;
    logic [7:0] pc;
    logic       stack_empty, stack_full, fault;

    int checks = 0;
    int errors = 0;

    exp_t       exp_q[$];
    logic [7:0] m_stack[$];
    logic [7:0] m_pc;
    logic       m_fault;

    pc_unit dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .enable      (enable),
        .op          (op),
        .target      (target),
        .pc          (pc),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    function automatic exp_t model_now();
        exp_t e;
        e.pc    = m_pc;
        e.empty = (m_stack.size() == 0);
        e.full  = (m_stack.size() == 4);
        e.fault = m_fault;
        return e;
    endfunction

    function automatic void model_reset();
        m_stack.delete();
        m_pc    = 8'h00;
        m_fault = 1'b0;
    endfunction

    function automatic void model_apply(logic en, logic [2:0] o, logic [7:0] t);
        logic [7:0] ret;
        if (!en || m_fault) return;
        case (o)
            3'd1: m_pc = m_pc + 8'd1;
            3'd2: m_pc = t;
            3'd3: begin
                if (m_stack.size() == 4) m_fault = 1'b1;
                else begin
                    ret = m_pc + 8'd1;
                    m_stack.push_back(ret);
                    m_pc = t;
                end
            end
            3'd4: begin
                if (m_stack.size() == 0) m_fault = 1'b1;
                else m_pc = m_stack.pop_back();
            end
            default: ;
        endcase
    endfunction

    task automatic compare(string name, exp_t act, exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got pc=%02h empty=%0b full=%0b fault=%0b, expected pc=%02h empty=%0b full=%0b fault=%0b",
                     name, act.pc, act.empty, act.full, act.fault,
                     exp.pc, exp.empty, exp.full, exp.fault);
        end
    endtask

    task automatic check_pc(string name, logic [7:0] want_pc, logic want_fault);
        checks++;
        if (pc !== want_pc || fault !== want_fault) begin
            errors++;
            $display("FAIL %s: got pc=%02h fault=%0b, expected pc=%02h fault=%0b",
                     name, pc, fault, want_pc, want_fault);
        end
    endtask

    task automatic step(logic en, logic [2:0] o, logic [7:0] t);
        enable = en;
        op     = o;
        target = t;
        @(posedge clock);
        #1;
        model_apply(en, o, t);
        exp_q.push_back(model_now());
    endtask

    // Asynchronous clear pulsed between edges, checked before any edge.
    task automatic pulse_clear();
        @(negedge clock);
        #1;
        clear_n = 1'b0;
        #1;
        model_reset();
        compare("async_clear", {pc, stack_empty, stack_full, fault}, model_now());
        #1;
        clear_n = 1'b1;
    endtask

    // Monitor: compares the DUT against each queued prediction.
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                compare("scoreboard", {pc, stack_empty, stack_full, fault}, exp_q.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        compare("reset_state", {pc, stack_empty, stack_full, fault}, model_now());
        clear_n = 1'b1;

        // 1: INC from reset
        repeat (3) step(1'b1, OP_INC, 8'h00);
        #2 check_pc("inc_x3", 8'h03, 1'b0);

        // 2: wrap
        step(1'b1, OP_JUMP, 8'hFE);
        step(1'b1, OP_INC, 8'h00);
        step(1'b1, OP_INC, 8'h00);
        #2 check_pc("wrap", 8'h00, 1'b0);

        // 3: nested call/return
        step(1'b1, OP_JUMP, 8'h10);
        step(1'b1, OP_CALL, 8'h40);
        step(1'b1, OP_CALL, 8'h80);
        step(1'b1, OP_RET, 8'h00);
        #2 check_pc("ret_inner", 8'h41, 1'b0);
        step(1'b1, OP_RET, 8'h00);
        #2 check_pc("ret_outer", 8'h11, 1'b0);

        // 4: overflow
        step(1'b1, OP_CALL, 8'h20);
        step(1'b1, OP_CALL, 8'h30);
        step(1'b1, OP_CALL, 8'h40);
        step(1'b1, OP_CALL, 8'h50);
        step(1'b1, OP_CALL, 8'h60);
        #2 check_pc("overflow", 8'h50, 1'b1);
        step(1'b1, OP_INC, 8'h00);
        step(1'b1, OP_JUMP, 8'h77);
        #2 check_pc("halted", 8'h50, 1'b1);

        // 5: underflow then asynchronous clear
        pulse_clear();
        step(1'b1, OP_RET, 8'h00);
        #2 check_pc("underflow", 8'h00, 1'b1);
        pulse_clear();

        // 6: enable low and reserved opcodes
        step(1'b1, OP_JUMP, 8'h33);
        repeat (3) step(1'b0, OP_JUMP, 8'hAA);
        step(1'b1, 3'b101, 8'hAA);
        step(1'b1, 3'b110, 8'hAA);
        step(1'b1, 3'b111, 8'hAA);
        #2 check_pc("hold", 8'h33, 1'b0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 600; i++) begin
            logic [2:0] o;
            if ($urandom_range(0, 39) == 0) pulse_clear();
            o = 3'($urandom_range(0, 9) < 8 ? $urandom_range(0, 4) : $urandom_range(5, 7));
            step(($urandom_range(0, 9) != 0), o, 8'($urandom));
        end

        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
